// File: rtl/io_bridge_if.sv
// Decoder-side I/O bus: strobes, byte offset, store data and combinational read data.
interface io_bridge_if;
    logic        IORead;
    logic        IOWrite;
    logic [9:0]  addr_low;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output IORead, output IOWrite, output addr_low, output wdata, input rdata);
    modport slave  (input IORead, input IOWrite, input addr_low, input wdata, output rdata);
endinterface

// File: rtl/io_bridge.sv
// Memory-mapped I/O stage: LED register, debounced switches, and 8-digit scanned seven-segment display.
module io_bridge #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [16:0] SCAN_CYCLES     = 17'd100000
) (
    input  logic             clock,
    input  logic             rst_n,
    io_bridge_if.slave       bus,
    input  logic [15:0]      switch_in,
    output logic [15:0]      led_out,
    output logic [7:0]       seg_out,
    output logic [7:0]       an_out
);
    localparam logic [9:0] ADDR_LED  = 10'h060;
    localparam logic [9:0] ADDR_SW   = 10'h070;
    localparam logic [9:0] ADDR_DISP = 10'h080;

    logic [15:0] led_q, led_d;
    logic [31:0] disp_q, disp_d;
    logic [15:0] sync1_q, sync2_q;
    logic [15:0] cand_q, cand_d;
    logic [15:0] stable_q, stable_d;
    logic [19:0] cnt_q, cnt_d;
    logic [16:0] scan_q, scan_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  digit [8];
    logic [3:0]  nibble;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            led_q    <= '0;
            disp_q   <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            scan_q   <= '0;
            idx_q    <= '0;
        end else begin
            led_q    <= led_d;
            disp_q   <= disp_d;
            sync1_q  <= switch_in;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            scan_q   <= scan_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        led_d  = led_q;
        disp_d = disp_q;
        if (bus.IOWrite) begin
            case (bus.addr_low)
                ADDR_LED:  led_d  = bus.wdata[15:0];
                ADDR_DISP: disp_d = bus.wdata;
                default:   ;
            endcase
        end
    end

    // Any disagreement restarts the hold count; the stable value updates only once the count saturates.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != DEBOUNCE_CYCLES - 20'd1)
                cnt_d = cnt_q + 20'd1;
            if (cnt_d == DEBOUNCE_CYCLES - 20'd1)
                stable_d = cand_q;
        end
    end

    always_comb begin
        scan_d = scan_q + 17'd1;
        idx_d  = idx_q;
        if (scan_q == SCAN_CYCLES - 17'd1) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            assign digit[gi] = disp_q[4*gi +: 4];
        end
    endgenerate

    assign nibble  = digit[idx_q];
    assign an_out  = ~(8'b0000_0001 << idx_q);
    assign led_out = led_q;

    // Glyphs are {dp,g..a} active-low; dp stays dark.
    always_comb begin
        case (nibble)
            4'h0: seg_out = 8'hC0;
            4'h1: seg_out = 8'hF9;
            4'h2: seg_out = 8'hA4;
            4'h3: seg_out = 8'hB0;
            4'h4: seg_out = 8'h99;
            4'h5: seg_out = 8'h92;
            4'h6: seg_out = 8'h82;
            4'h7: seg_out = 8'hF8;
            4'h8: seg_out = 8'h80;
            4'h9: seg_out = 8'h90;
            4'hA: seg_out = 8'h88;
            4'hB: seg_out = 8'h83;
            4'hC: seg_out = 8'hC6;
            4'hD: seg_out = 8'hA1;
            4'hE: seg_out = 8'h86;
            default: seg_out = 8'h8E;
        endcase
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.IORead) begin
            case (bus.addr_low)
                ADDR_LED:  bus.rdata = {16'b0, led_q};
                ADDR_SW:   bus.rdata = {16'b0, stable_q};
                ADDR_DISP: bus.rdata = disp_q;
                default:   bus.rdata = '0;
            endcase
        end
    end
endmodule
